// File: rtl/sw_align_ctrl.sv
// Purpose: Smith-Waterman PE-array sequencer; loads query/database bytes, streams bases, tracks best score.
// Latency: start accepted at edge T -> output_valid at edge T + DLEN/4 + DLEN + QLEN (56 with defaults).
// Backpressure: none; start is taken only while ready=1, abort wins over start, nothing is queued.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   start, abort                 job request (accepted while ready) / synchronous job abort
//   query_seq_in, database_seq_in  4 packed 2-bit bases per byte, [7:6] is the lowest index
//   ready, output_valid          idle-or-done / result valid (held until next start or abort)
//   score, end_pos               best local score and the database index where it occurred
//   q_wr_en, q_wr_addr, q_wr_data  query byte write into PE group q_wr_addr
//   array_clr                    clear all PE H/E/F registers
//   d_valid, d_base              database base stream into PE0
//   pe_score_vld, pe_score, pe_dpos  cell score candidates coming back from the array
module sw_align_ctrl #(
  parameter int QLEN    = 16,
  parameter int DLEN    = 32,
  parameter int SCORE_W = 7,
  parameter int POS_W   = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [7:0]         query_seq_in,
  input  logic [7:0]         database_seq_in,
  output logic               ready,
  output logic               output_valid,
  output logic [SCORE_W-1:0] score,
  output logic [POS_W-1:0]   end_pos,
  output logic               q_wr_en,
  output logic [1:0]         q_wr_addr,
  output logic [7:0]         q_wr_data,
  output logic               array_clr,
  output logic               d_valid,
  output logic [1:0]         d_base,
  input  logic               pe_score_vld,
  input  logic [SCORE_W-1:0] pe_score,
  input  logic [POS_W-1:0]   pe_dpos
);

  localparam int NWORDS = DLEN / 4;
  localparam int CNT_W  = $clog2(DLEN);
  localparam int WA_W   = CNT_W - 2;

  localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(NWORDS - 1);
  localparam logic [CNT_W-1:0] STRM_LAST  = CNT_W'(DLEN - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(QLEN - 1);
  localparam logic [CNT_W-1:0] QWORDS     = CNT_W'(QLEN / 4);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [7:0]         r_dbuf [NWORDS];
  logic [SCORE_W-1:0] r_best;
  logic [POS_W-1:0]   r_best_pos;

  logic               r_ready;
  logic               r_output_valid;
  logic [SCORE_W-1:0] r_score;
  logic [POS_W-1:0]   r_end_pos;
  logic               r_q_wr_en;
  logic [1:0]         r_q_wr_addr;
  logic [7:0]         r_q_wr_data;
  logic               r_array_clr;
  logic               r_d_valid;
  logic [1:0]         r_d_base;

  logic [CNT_W-1:0]   w_nxt_i;
  logic [7:0]         w_word;
  logic [1:0]         w_nxt_base;
  logic               w_track;
  logic [SCORE_W-1:0] w_best_nxt;
  logic [POS_W-1:0]   w_pos_nxt;

  // d_base is registered, so look one base ahead: index 0 when leaving LOAD, i+1 while streaming.
  assign w_nxt_i = (r_state == ST_STREAM) ? r_cnt + CNT_W'(1) : '0;
  assign w_word  = r_dbuf[w_nxt_i[CNT_W-1:2]];

  always_comb begin
    w_nxt_base = w_word[7:6];
    case (w_nxt_i[1:0])
      2'd0:    w_nxt_base = w_word[7:6];
      2'd1:    w_nxt_base = w_word[5:4];
      2'd2:    w_nxt_base = w_word[3:2];
      default: w_nxt_base = w_word[1:0];
    endcase
  end

  // Strictly-greater update so a tie keeps the earlier position.
  assign w_track    = ((r_state == ST_STREAM) || (r_state == ST_DRAIN)) &&
                      pe_score_vld && (pe_score > r_best);
  assign w_best_nxt = w_track ? pe_score : r_best;
  assign w_pos_nxt  = w_track ? pe_dpos  : r_best_pos;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_best         <= '0;
      r_best_pos     <= '0;
      r_ready        <= 1'b1;
      r_output_valid <= 1'b0;
      r_score        <= '0;
      r_end_pos      <= '0;
      r_q_wr_en      <= 1'b0;
      r_q_wr_addr    <= '0;
      r_q_wr_data    <= '0;
      r_array_clr    <= 1'b0;
      r_d_valid      <= 1'b0;
      r_d_base       <= '0;
      for (int k = 0; k < NWORDS; k++) r_dbuf[k] <= '0;
    end else begin
      // Single-cycle strobes default low.
      r_q_wr_en   <= 1'b0;
      r_array_clr <= 1'b0;
      r_d_valid   <= 1'b0;
      r_d_base    <= '0;
      if (abort) begin
        r_state        <= ST_IDLE;
        r_cnt          <= '0;
        r_ready        <= 1'b1;
        r_output_valid <= 1'b0;
        r_score        <= '0;
        r_end_pos      <= '0;
        r_best         <= '0;
        r_best_pos     <= '0;
        r_array_clr    <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE, ST_DONE: begin
            if (start) begin
              r_state        <= ST_LOAD;
              r_cnt          <= '0;
              r_ready        <= 1'b0;
              r_output_valid <= 1'b0;
              r_score        <= '0;
              r_end_pos      <= '0;
              r_best         <= '0;
              r_best_pos     <= '0;
              // Single-word database: the first LOAD cycle is also the last.
              if (LOAD_LAST == '0) r_array_clr <= 1'b1;
            end
          end
          ST_LOAD: begin
            r_dbuf[r_cnt[WA_W-1:0]] <= database_seq_in;
            r_best     <= '0;
            r_best_pos <= '0;
            if (r_cnt < QWORDS) begin
              r_q_wr_en   <= 1'b1;
              r_q_wr_addr <= r_cnt[1:0];
              r_q_wr_data <= query_seq_in;
            end
            if (r_cnt == LOAD_LAST) begin
              r_state   <= ST_STREAM;
              r_cnt     <= '0;
              r_d_valid <= 1'b1;
              r_d_base  <= w_nxt_base;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
              // Registered strobe: raise it so it is visible during the last LOAD cycle.
              if (r_cnt + CNT_W'(1) == LOAD_LAST) r_array_clr <= 1'b1;
            end
          end
          ST_STREAM: begin
            r_best     <= w_best_nxt;
            r_best_pos <= w_pos_nxt;
            if (r_cnt == STRM_LAST) begin
              r_state <= ST_DRAIN;
              r_cnt   <= '0;
            end else begin
              r_cnt     <= r_cnt + CNT_W'(1);
              r_d_valid <= 1'b1;
              r_d_base  <= w_nxt_base;
            end
          end
          ST_DRAIN: begin
            r_best     <= w_best_nxt;
            r_best_pos <= w_pos_nxt;
            if (r_cnt == DRAIN_LAST) begin
              // Include a candidate arriving in the final drain cycle.
              r_state        <= ST_DONE;
              r_cnt          <= '0;
              r_score        <= w_best_nxt;
              r_end_pos      <= w_pos_nxt;
              r_output_valid <= 1'b1;
              r_ready        <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ready <= 1'b1;
          end
        endcase
      end
    end
  end

  assign ready        = r_ready;
  assign output_valid = r_output_valid;
  assign score        = r_score;
  assign end_pos      = r_end_pos;
  assign q_wr_en      = r_q_wr_en;
  assign q_wr_addr    = r_q_wr_addr;
  assign q_wr_data    = r_q_wr_data;
  assign array_clr    = r_array_clr;
  assign d_valid      = r_d_valid;
  assign d_base       = r_d_base;

endmodule

// File: tb/tb_sw_align_ctrl.sv
// Purpose: directed self-checking bench for sw_align_ctrl with hand-computed expectations.
// Latency: checks the start-to-output_valid distance of 56 edges cycle by cycle.
// Backpressure: covers abort priority, ignored start, back-to-back jobs and async reset.
module tb_sw_align_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] query_seq_in;
  logic [7:0] database_seq_in;
  logic       ready;
  logic       output_valid;
  logic [6:0] score;
  logic [4:0] end_pos;
  logic       q_wr_en;
  logic [1:0] q_wr_addr;
  logic [7:0] q_wr_data;
  logic       array_clr;
  logic       d_valid;
  logic [1:0] d_base;
  logic       pe_score_vld;
  logic [6:0] pe_score;
  logic [4:0] pe_dpos;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] qb [4] = '{8'h1B, 8'hE4, 8'h00, 8'hFF};

  // Score events for the PE side: cycle offset after start, score, position.
  int ev_n [8];
  int ev_s [8];
  int ev_p [8];
  int ev_num = 0;

  sw_align_ctrl #(.QLEN(16), .DLEN(32), .SCORE_W(7), .POS_W(5)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .abort           (abort),
    .query_seq_in    (query_seq_in),
    .database_seq_in (database_seq_in),
    .ready           (ready),
    .output_valid    (output_valid),
    .score           (score),
    .end_pos         (end_pos),
    .q_wr_en         (q_wr_en),
    .q_wr_addr       (q_wr_addr),
    .q_wr_data       (q_wr_data),
    .array_clr       (array_clr),
    .d_valid         (d_valid),
    .d_base          (d_base),
    .pe_score_vld    (pe_score_vld),
    .pe_score        (pe_score),
    .pe_dpos         (pe_dpos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Database byte b equals b; base i is byte i/4 unpacked MSB first.
  function automatic int exp_base(input int i);
    int b;
    b = i / 4;
    return (b >> (2 * (3 - (i % 4)))) & 3;
  endfunction

  task automatic drive_cycle(input int n);
    database_seq_in = (n < 8) ? 8'(n) : 8'hC3;
    query_seq_in    = (n < 4) ? qb[n] : 8'h5A;
    pe_score_vld    = 1'b0;
    pe_score        = '0;
    pe_dpos         = '0;
    for (int k = 0; k < ev_num; k++) begin
      if (ev_n[k] == n) begin
        pe_score_vld = 1'b1;
        pe_score     = 7'(ev_s[k]);
        pe_dpos      = 5'(ev_p[k]);
      end
    end
  endtask

  // Called just after a negedge; returns at the negedge of the first DONE cycle.
  task automatic run_job(input string nm, input int exp_s, input int exp_p);
    start = 1'b1;
    @(posedge clk);
    for (int n = 0; n <= 56; n++) begin
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("%s_qwr@%0d", nm, n), 32'(q_wr_en), 32'(n >= 1 && n <= 4));
      if (n >= 1 && n <= 4) begin
        chk($sformatf("%s_qaddr@%0d", nm, n), 32'(q_wr_addr), 32'(n - 1));
        chk($sformatf("%s_qdat@%0d", nm, n), 32'(q_wr_data), 32'(qb[n-1]));
      end
      chk($sformatf("%s_clr@%0d", nm, n), 32'(array_clr), 32'(n == 7));
      chk($sformatf("%s_dvld@%0d", nm, n), 32'(d_valid), 32'(n >= 8 && n < 40));
      if (n >= 8 && n < 40)
        chk($sformatf("%s_dbase@%0d", nm, n), 32'(d_base), 32'(exp_base(n - 8)));
      chk($sformatf("%s_ovld@%0d", nm, n), 32'(output_valid), 32'(n == 56));
      chk($sformatf("%s_rdy@%0d", nm, n), 32'(ready), 32'(n == 56));
      if (n == 0) chk($sformatf("%s_score_clr", nm), 32'(score), 32'd0);
      if (n == 56) begin
        chk($sformatf("%s_score", nm), 32'(score), 32'(exp_s));
        chk($sformatf("%s_endpos", nm), 32'(end_pos), 32'(exp_p));
      end
      if (n < 56) drive_cycle(n);
    end
    drive_cycle(99);
  endtask

  task automatic set_ev(input int k, input int n, input int s, input int p);
    ev_n[k] = n;
    ev_s[k] = s;
    ev_p[k] = p;
  endtask

  initial begin
    int clr_cnt;
    int bad;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    drive_cycle(99);

    // 1) Reset and idle.
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_ovld", 32'(output_valid), 32'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      pe_score_vld = 1'b1;
      pe_score     = 7'd120;
      chk($sformatf("idle_qwr@%0d", c), 32'(q_wr_en), 32'd0);
      chk($sformatf("idle_dvld@%0d", c), 32'(d_valid), 32'd0);
      chk($sformatf("idle_rdy@%0d", c), 32'(ready), 32'd1);
      chk($sformatf("idle_ovld@%0d", c), 32'(output_valid), 32'd0);
      chk($sformatf("idle_score@%0d", c), 32'(score), 32'd0);
    end
    drive_cycle(99);

    // 2) Basic job, no candidates.
    ev_num = 0;
    run_job("basic", 0, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("basic_hold_ovld@%0d", c), 32'(output_valid), 32'd1);
      chk($sformatf("basic_hold_rdy@%0d", c), 32'(ready), 32'd1);
    end

    // 3) Tie and update; the LOAD-time candidate must be ignored.
    set_ev(0, 13, 5, 3);
    set_ev(1, 20, 9, 10);
    set_ev(2, 22, 9, 12);
    set_ev(3, 30, 4, 20);
    set_ev(4, 2, 100, 7);
    ev_num = 5;
    run_job("tie", 9, 10);

    // 5) Back-to-back: start in the first DONE cycle; last-drain candidate counts.
    set_ev(0, 3, 127, 1);
    set_ev(1, 8, 3, 0);
    set_ev(2, 55, 12, 25);
    ev_num = 3;
    run_job("b2b", 12, 25);
    ev_num = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("b2b_hold_score@%0d", c), 32'(score), 32'd12);
      chk($sformatf("b2b_hold_ovld@%0d", c), 32'(output_valid), 32'd1);
    end

    // 4) Abort on STREAM cycle 7 (cycle 15 after start).
    start = 1'b1;
    @(posedge clk);
    for (int n = 0; n <= 15; n++) begin
      @(negedge clk);
      start = 1'b0;
      drive_cycle(n);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_dvld", 32'(d_valid), 32'd0);
    chk("abort_clr", 32'(array_clr), 32'd1);
    chk("abort_rdy", 32'(ready), 32'd1);
    chk("abort_ovld", 32'(output_valid), 32'd0);
    chk("abort_score", 32'(score), 32'd0);
    clr_cnt = 0;
    bad = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      drive_cycle(99);
      if (array_clr) clr_cnt++;
      if (output_valid || d_valid || q_wr_en) bad++;
    end
    chk("abort_clr_once", 32'(clr_cnt), 32'd0);
    chk("abort_quiet", 32'(bad), 32'd0);

    // Abort wins over start in the same cycle.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("abstart_rdy", 32'(ready), 32'd1);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!ready || q_wr_en || d_valid || output_valid) bad++;
    end
    chk("abstart_not_started", 32'(bad), 32'd0);

    // 6) Async reset mid-DRAIN (cycle 45 after start).
    start = 1'b1;
    @(posedge clk);
    for (int n = 0; n <= 45; n++) begin
      @(negedge clk);
      start = 1'b0;
      drive_cycle(n);
    end
    chk("pre_rst_rdy", 32'(ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rdy", 32'(ready), 32'd1);
    chk("arst_ovld", 32'(output_valid), 32'd0);
    chk("arst_score", 32'(score), 32'd0);
    chk("arst_endpos", 32'(end_pos), 32'd0);
    chk("arst_qwr", 32'(q_wr_en), 32'd0);
    chk("arst_qaddr", 32'(q_wr_addr), 32'd0);
    chk("arst_qdat", 32'(q_wr_data), 32'd0);
    chk("arst_clr", 32'(array_clr), 32'd0);
    chk("arst_dvld", 32'(d_valid), 32'd0);
    chk("arst_dbase", 32'(d_base), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rdy", 32'(ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
